// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
// Drives a shared up-counter (load / load_value / en) and watches its count
// output to produce periodic or one-shot interval ticks.
//
// Ports:
//   clk, rst_n        clock (shared with the counter), async active-low reset
//   cfg_valid/ready   configuration handshake, accepted only in IDLE
//   cfg_start/limit   counter preload and terminal values (start <= limit)
//   cfg_oneshot       1 = stop after the first tick, 0 = periodic
//   stop              abort a running interval (LOAD or RUN)
//   count             counter output
//   cnt_load, cnt_load_value, cnt_en   counter controls
//   tick              pulse on the RUN cycle where count == limit
//   done              pulse on one-shot completion
//   cfg_err           pulse the cycle after a rejected configuration
//   busy              controller not idle
//   tick_count        saturating tick count since last accepted config
module interval_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_oneshot,
  input  logic             stop,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_value,
  output logic             cnt_en,
  output logic             tick,
  output logic             done,
  output logic             cfg_err,
  output logic             busy,
  output logic [WIDTH-1:0] tick_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] limit_q;
  logic             oneshot_q;
  logic [WIDTH-1:0] tick_count_reg;
  logic             cfg_err_reg;

  logic cfg_fire;
  logic cfg_ok;
  logic hit;

  assign cfg_fire = cfg_valid && (state_reg == IDLE);
  assign cfg_ok   = (cfg_start <= cfg_limit);
  // Exact equality: if the counter was pushed past the limit externally it
  // keeps counting until it wraps round to the limit again.
  assign hit      = (count == limit_q);

  assign cfg_ready      = (state_reg == IDLE);
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign cnt_load_value = start_q;
  assign tick_count     = tick_count_reg;
  assign cfg_err        = cfg_err_reg;

  // Next state and combinational counter controls. stop takes priority over
  // hit so an aborted interval never reloads or ticks.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    tick       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_fire && cfg_ok) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          cnt_load   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (hit) begin
          tick = 1'b1;
          if (oneshot_q) begin
            state_next = DONE;
          end else begin
            cnt_load = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      start_q        <= '0;
      limit_q        <= '0;
      oneshot_q      <= 1'b0;
      tick_count_reg <= '0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= cfg_fire && !cfg_ok;
      if (cfg_fire && cfg_ok) begin
        start_q        <= cfg_start;
        limit_q        <= cfg_limit;
        oneshot_q      <= cfg_oneshot;
        tick_count_reg <= '0;
      end else if (tick && (tick_count_reg != '1)) begin
        tick_count_reg <= tick_count_reg + 1'b1;
      end
    end
  end

endmodule
